i2c_target_core: RTL and testbench

//  I2C target (slave) for the SDA/SCL bus driven by master_i2c. Oversamples both lines on clk,

---
 rtl/i2c_target_core_pkg.sv | 19 +
 rtl/i2c_target_core_if.sv | 16 +
 rtl/i2c_target_core_line_filter.sv | 66 ++++++
 rtl/i2c_target_core.sv | 164 ++++++++++++++++
 tb/tb_i2c_target_core.sv | 289 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/i2c_target_core_pkg.sv
// Shared state encoding and ACK/NACK levels for the I2C target core.
package i2c_target_core_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_ADDR    = 3'd1,
        ST_ACK     = 3'd2,
        ST_WR_DATA = 3'd3,
        ST_WR_ACK  = 3'd4,
        ST_RD_DATA = 3'd5,
        ST_RD_ACK  = 3'd6,
        ST_IGNORE  = 3'd7
    } state_e;

    localparam logic       I2C_ACK      = 1'b0;
    localparam logic       I2C_NACK     = 1'b1;
    localparam logic [3:0] BIT_CNT_LAST = 4'd8;

endpackage

// File: rtl/i2c_target_core_if.sv
// User-side handshake plus SCL for the I2C target. SDA stays a plain inout on the top
// so the open-drain bus resolves at the level where the pull-up lives.
interface i2c_target_core_if;
    logic       scl;
    logic [7:0] tx_data;
    logic       tx_ld;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       busy;
    logic       rw_dir;

    // tx_ld / rx_valid are single-cycle strobes: tx_data is captured in the tx_ld cycle,
    // rx_data is valid from the rx_valid cycle and held until the next rx_valid.
    modport slave  (input scl, tx_data, output tx_ld, rx_data, rx_valid, busy, rw_dir);
    modport master (output scl, tx_data, input tx_ld, rx_data, rx_valid, busy, rw_dir);
endinterface

// File: rtl/i2c_target_core_line_filter.sv
// 2-FF synchronizer plus, with I2C_TGT_GLITCH_FILTER_EN, a FILT_LEN persistence filter.
// Produces the accepted line level and single-cycle rise/fall flags.
module i2c_target_core_line_filter #(
    parameter int unsigned FILT_LEN = 3
) (
    input  logic clk,
    input  logic reset,
    input  logic line_i,
    output logic level,
    output logic rise,
    output logic fall
);
    logic [1:0] sync_q, sync_d;
    logic       prev_q, prev_d;
    logic       lvl;

`ifdef I2C_TGT_GLITCH_FILTER_EN
    localparam int unsigned CW = (FILT_LEN > 1) ? $clog2(FILT_LEN) : 1;
    logic          filt_q, filt_d;
    logic [CW-1:0] run_q, run_d;

    // Level flips only after FILT_LEN consecutive samples disagree with it.
    always_comb begin
        filt_d = filt_q;
        run_d  = '0;
        if (sync_q[1] != filt_q) begin
            if (run_q == CW'(FILT_LEN - 1)) filt_d = sync_q[1];
            else                            run_d  = run_q + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            filt_q <= 1'b1;
            run_q  <= '0;
        end else begin
            filt_q <= filt_d;
            run_q  <= run_d;
        end
    end

    assign lvl = filt_q;
`else
    assign lvl = sync_q[1];
`endif

    always_comb begin
        sync_d = {sync_q[0], line_i};
        prev_d = lvl;
    end

    // Idle bus is high, so reset to 1 to avoid a false edge after reset.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync_q <= 2'b11;
            prev_q <= 1'b1;
        end else begin
            sync_q <= sync_d;
            prev_q <= prev_d;
        end
    end

    assign level = lvl;
    assign rise  = lvl & ~prev_q;
    assign fall  = ~lvl & prev_q;
endmodule

// File: rtl/i2c_target_core.sv
// I2C target: START/STOP detect, 7-bit address match, write/read byte engine, no clock
// stretching. I2C_TGT_GLITCH_FILTER_EN enables the FILT_LEN line filter.
module i2c_target_core
    import i2c_target_core_pkg::*;
#(
    parameter logic [6:0]  SLAVE_ADDR = 7'h6A,
    parameter int unsigned FILT_LEN   = 3
) (
    input  logic                clk,
    input  logic                reset,
    i2c_target_core_if.slave    bus,
    inout  wire                 sda,
    output state_e              dbg_state
);
    logic scl_lvl, scl_rise, scl_fall;
    logic sda_lvl, sda_rise, sda_fall;
    logic start_det, stop_det;
    logic [7:0] byte_in;

    state_e     state_q, state_d;
    logic [3:0] cnt_q, cnt_d;
    logic [7:0] shift_q, shift_d;
    logic [7:0] rx_data_q, rx_data_d;
    logic       oe_q, oe_d;
    logic       rx_valid_q, rx_valid_d;
    logic       tx_ld_q, tx_ld_d;
    logic       busy_q, busy_d;
    logic       rw_dir_q, rw_dir_d;

    i2c_target_core_line_filter #(.FILT_LEN(FILT_LEN)) u_scl_filt (
        .clk(clk), .reset(reset), .line_i(bus.scl),
        .level(scl_lvl), .rise(scl_rise), .fall(scl_fall)
    );

    i2c_target_core_line_filter #(.FILT_LEN(FILT_LEN)) u_sda_filt (
        .clk(clk), .reset(reset), .line_i(sda),
        .level(sda_lvl), .rise(sda_rise), .fall(sda_fall)
    );

    assign start_det = sda_fall & scl_lvl;
    assign stop_det  = sda_rise & scl_lvl;
    assign byte_in   = {shift_q[6:0], sda_lvl};

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        shift_d    = shift_q;
        oe_d       = oe_q;
        rx_data_d  = rx_data_q;
        rx_valid_d = 1'b0;
        tx_ld_d    = 1'b0;
        busy_d     = busy_q;
        rw_dir_d   = rw_dir_q;
        if (stop_det) begin
            state_d = ST_IDLE;
            oe_d    = 1'b0;
            busy_d  = 1'b0;
        end else if (start_det) begin
            state_d = ST_ADDR;
            oe_d    = 1'b0;
            cnt_d   = 4'd0;
        end else begin
            case (state_q)
                ST_ADDR: if (scl_rise) begin
                    shift_d = byte_in;
                    cnt_d   = cnt_q + 4'd1;
                    if (cnt_q == BIT_CNT_LAST - 4'd1) begin
                        if (byte_in[7:1] == SLAVE_ADDR && byte_in[7:1] != 7'd0) begin
                            state_d  = ST_ACK;
                            busy_d   = 1'b1;
                            rw_dir_d = byte_in[0];
                        end else begin
                            state_d = ST_IGNORE;
                            busy_d  = 1'b0;
                        end
                    end
                end
                // First falling flag opens the ACK slot, the second one closes it.
                ST_ACK, ST_WR_ACK: if (scl_fall) begin
                    if (!oe_q) begin
                        oe_d = 1'b1;
                    end else begin
                        cnt_d = 4'd0;
                        if (state_q == ST_ACK && rw_dir_q) begin
                            state_d = ST_RD_DATA;
                            shift_d = bus.tx_data;
                            tx_ld_d = 1'b1;
                            oe_d    = (bus.tx_data[7] == I2C_ACK);
                        end else begin
                            state_d = ST_WR_DATA;
                            oe_d    = 1'b0;
                        end
                    end
                end
                ST_WR_DATA: if (scl_rise) begin
                    shift_d = byte_in;
                    cnt_d   = cnt_q + 4'd1;
                    if (cnt_q == BIT_CNT_LAST - 4'd1) begin
                        rx_data_d  = byte_in;
                        rx_valid_d = 1'b1;
                        state_d    = ST_WR_ACK;
                    end
                end
                ST_RD_DATA: begin
                    if (scl_rise) begin
                        cnt_d = cnt_q + 4'd1;
                    end else if (scl_fall) begin
                        if (cnt_q == BIT_CNT_LAST) begin
                            oe_d    = 1'b0;
                            state_d = ST_RD_ACK;
                        end else begin
                            shift_d = {shift_q[6:0], 1'b0};
                            oe_d    = (shift_q[6] == 1'b0);
                        end
                    end
                end
                ST_RD_ACK: begin
                    if (scl_rise && sda_lvl == I2C_NACK) begin
                        state_d = ST_IGNORE;
                    end else if (scl_fall) begin
                        state_d = ST_RD_DATA;
                        cnt_d   = 4'd0;
                        shift_d = bus.tx_data;
                        tx_ld_d = 1'b1;
                        oe_d    = (bus.tx_data[7] == I2C_ACK);
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            cnt_q      <= 4'd0;
            shift_q    <= 8'h00;
            oe_q       <= 1'b0;
            rx_data_q  <= 8'h00;
            rx_valid_q <= 1'b0;
            tx_ld_q    <= 1'b0;
            busy_q     <= 1'b0;
            rw_dir_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            shift_q    <= shift_d;
            oe_q       <= oe_d;
            rx_data_q  <= rx_data_d;
            rx_valid_q <= rx_valid_d;
            tx_ld_q    <= tx_ld_d;
            busy_q     <= busy_d;
            rw_dir_q   <= rw_dir_d;
        end
    end

    assign sda          = oe_q ? 1'b0 : 1'bz;
    assign bus.tx_ld    = tx_ld_q;
    assign bus.rx_data  = rx_data_q;
    assign bus.rx_valid = rx_valid_q;
    assign bus.busy     = busy_q;
    assign bus.rw_dir   = rw_dir_q;
    assign dbg_state    = state_q;
endmodule

// File: tb/tb_i2c_target_core.sv
// Bench for i2c_target_core: bit-level I2C master, transaction-level expectations, and one
// per-cycle monitor for rx/tx strobes and bus release.
module tb_i2c_target_core;
    import i2c_target_core_pkg::*;

    localparam logic [6:0] SLAVE_ADDR = 7'h6A;
    localparam int         Q          = 6;

    logic   clk = 1'b0;
    logic   reset;
    logic   m_low;
    wire    sda;
    state_e dbg_state;

    always #5 clk = ~clk;

    i2c_target_core_if bus_if();

    assign sda = m_low ? 1'b0 : 1'bz;
    pullup (sda);

    i2c_target_core #(.SLAVE_ADDR(SLAVE_ADDR), .FILT_LEN(3)) dut (
        .clk(clk), .reset(reset), .bus(bus_if), .sda(sda), .dbg_state(dbg_state)
    );

    int         checks   = 0;
    int         failures = 0;
    logic [7:0] exp_rx_q[$];
    logic [7:0] tx_src_q[$];
    logic [7:0] plan_q[$];
    logic [7:0] exp_b;
    logic [7:0] model_rx = 8'h00;
    logic [7:0] last_rd  = 8'h00;
    logic       exp_release = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Monitor: strobes against the expected queues, and bus release where required.
    always @(negedge clk) begin
        if (!reset) begin
            if (bus_if.rx_valid) begin
                checks++;
                if (exp_rx_q.size() == 0) begin
                    failures++;
                    $display("FAIL rx_unexpected: got rx_valid with rx_data=0x%0h expected none", bus_if.rx_data);
                end else begin
                    exp_b = exp_rx_q.pop_front();
                    if (bus_if.rx_data !== exp_b) begin
                        failures++;
                        $display("FAIL rx_data: got 0x%0h expected 0x%0h", bus_if.rx_data, exp_b);
                    end
                end
            end
            if (bus_if.tx_ld) begin
                checks++;
                if (tx_src_q.size() == 0) begin
                    failures++;
                    $display("FAIL tx_ld_unexpected: got tx_ld expected none");
                end else begin
                    void'(tx_src_q.pop_front());
                end
            end
            if (exp_release && !m_low) begin
                checks++;
                if (sda !== 1'b1) begin
                    failures++;
                    $display("FAIL sda_release: got sda=%b expected 1 (released)", sda);
                end
            end
        end
        bus_if.tx_data = (tx_src_q.size() != 0) ? tx_src_q[0] : 8'h00;
    end

    task automatic clk_n(input int n);
        repeat (n) @(negedge clk);
    endtask

    // One SCL period, entered and left with SCL low.
    task automatic bit_xfer(input logic b, input bit glitch, output logic s);
        if (glitch) begin
            clk_n(2); bus_if.scl = 1'b1; clk_n(1); bus_if.scl = 1'b0; clk_n(Q - 3);
        end else begin
            clk_n(Q);
        end
        m_low = ~b;
        clk_n(Q); bus_if.scl = 1'b1;
        clk_n(Q); s = sda;
        clk_n(Q); bus_if.scl = 1'b0;
    endtask

    task automatic gen_start();
        clk_n(Q); m_low = 1'b0;
        clk_n(Q); bus_if.scl = 1'b1;
        clk_n(Q); m_low = 1'b1;
        clk_n(Q); bus_if.scl = 1'b0;
    endtask

    task automatic gen_stop();
        clk_n(Q); m_low = 1'b1;
        clk_n(Q); bus_if.scl = 1'b1;
        clk_n(Q); m_low = 1'b0;
        clk_n(2 * Q);
    endtask

    task automatic write_byte(input logic [7:0] b, input bit glitch, output logic ack);
        logic s;
        for (int i = 7; i >= 0; i--) bit_xfer(b[i], glitch && (i == 3), s);
        bit_xfer(1'b1, 1'b0, ack);
    endtask

    task automatic read_byte(input logic nack, output logic [7:0] b);
        logic s;
        for (int i = 7; i >= 0; i--) begin
            bit_xfer(1'b1, 1'b0, s);
            b[i] = s;
        end
        bit_xfer(nack, 1'b0, s);
    endtask

    task automatic do_write(input logic [6:0] addr, input bit glitch);
        logic ack;
        bit   match;
        match       = (addr == SLAVE_ADDR) && (addr != 7'd0);
        exp_release = !match;
        gen_start();
        write_byte({addr, 1'b0}, 1'b0, ack);
        check("wr_addr_ack", 32'(ack), match ? 32'd0 : 32'd1);
        check("wr_busy", 32'(bus_if.busy), 32'(match));
        if (match) check("wr_rw_dir", 32'(bus_if.rw_dir), 32'd0);
        foreach (plan_q[i]) begin
            if (match) begin
                exp_rx_q.push_back(plan_q[i]);
                model_rx = plan_q[i];
            end
            write_byte(plan_q[i], glitch && (i == 0), ack);
            check("wr_data_ack", 32'(ack), match ? 32'd0 : 32'd1);
        end
        gen_stop();
        exp_release = 1'b0;
        check("wr_busy_after_stop", 32'(bus_if.busy), 32'd0);
        check("wr_rx_drained", 32'(exp_rx_q.size()), 32'd0);
        check("wr_rx_held", 32'(bus_if.rx_data), 32'(model_rx));
    endtask

    task automatic do_read(input logic [6:0] addr);
        logic       ack;
        logic [7:0] got;
        bit         match;
        match       = (addr == SLAVE_ADDR) && (addr != 7'd0);
        exp_release = !match;
        if (match) foreach (plan_q[i]) tx_src_q.push_back(plan_q[i]);
        gen_start();
        write_byte({addr, 1'b1}, 1'b0, ack);
        check("rd_addr_ack", 32'(ack), match ? 32'd0 : 32'd1);
        check("rd_busy", 32'(bus_if.busy), 32'(match));
        if (match) begin
            check("rd_rw_dir", 32'(bus_if.rw_dir), 32'd1);
            foreach (plan_q[i]) begin
                read_byte(i == plan_q.size() - 1, got);
                check("rd_byte", 32'(got), 32'(plan_q[i]));
                last_rd = got;
            end
            exp_release = 1'b1;
            check("rd_ignore_state", 32'(dbg_state), 32'(ST_IGNORE));
            check("rd_busy_until_stop", 32'(bus_if.busy), 32'd1);
            clk_n(4 * Q);
        end
        gen_stop();
        exp_release = 1'b0;
        check("rd_busy_after_stop", 32'(bus_if.busy), 32'd0);
        check("rd_tx_loads", 32'(tx_src_q.size()), 32'd0);
    endtask

    initial begin
        logic       ack;
        logic       s;
        logic [6:0] a;
        int         n;

        reset      = 1'b1;
        m_low      = 1'b0;
        bus_if.scl = 1'b1;
        clk_n(5);
        check("reset_sda", 32'(sda), 32'd1);
        check("reset_rx_data", 32'(bus_if.rx_data), 32'h00);
        check("reset_busy", 32'(bus_if.busy), 32'd0);
        check("reset_state", 32'(dbg_state), 32'(ST_IDLE));
        reset = 1'b0;
        clk_n(4 * Q);

        // Single byte write.
        plan_q = '{8'hB0};
        do_write(SLAVE_ADDR, 1'b0);
        check("t1_rx_data", 32'(bus_if.rx_data), 32'hB0);

        // Single byte read, master NACK.
        plan_q = '{8'hAC};
        do_read(SLAVE_ADDR);
        check("t2_read_byte", 32'(last_rd), 32'hAC);

        // Two byte read: ACK then NACK.
        plan_q = '{8'h5A, 8'hC3};
        do_read(SLAVE_ADDR);
        check("t3_last_byte", 32'(last_rd), 32'hC3);

        // Wrong address and general call are ignored.
        plan_q = '{8'hF0};
        do_write(7'h72, 1'b0);
        do_write(7'h00, 1'b0);

        // STOP after 4 data bits discards the byte; read follows.
        exp_release = 1'b0;
        gen_start();
        write_byte({SLAVE_ADDR, 1'b0}, 1'b0, ack);
        check("t5_addr_ack", 32'(ack), 32'd0);
        for (int i = 0; i < 4; i++) bit_xfer(1'($urandom_range(0, 1)), 1'b0, s);
        gen_stop();
        check("t5_busy", 32'(bus_if.busy), 32'd0);
        check("t5_rx_held", 32'(bus_if.rx_data), 32'hB0);
        plan_q = '{8'h3C};
        do_read(SLAVE_ADDR);

        // Repeated START to another address drops busy.
        gen_start();
        write_byte({SLAVE_ADDR, 1'b0}, 1'b0, ack);
        exp_rx_q.push_back(8'h11);
        model_rx = 8'h11;
        write_byte(8'h11, 1'b0, ack);
        check("t7_data_ack", 32'(ack), 32'd0);
        gen_start();
        write_byte({7'h72, 1'b0}, 1'b0, ack);
        check("t7_sr_nack", 32'(ack), 32'd1);
        check("t7_sr_busy", 32'(bus_if.busy), 32'd0);
        gen_stop();

`ifdef I2C_TGT_GLITCH_FILTER_EN
        plan_q = '{8'h96};
        do_write(SLAVE_ADDR, 1'b1);
`endif

        // Randomized transactions.
        for (int t = 0; t < 12; t++) begin
            a = ($urandom_range(0, 3) != 0) ? SLAVE_ADDR : 7'($urandom_range(0, 127));
            n = $urandom_range(1, 3);
            plan_q.delete();
            repeat (n) plan_q.push_back(8'($urandom_range(0, 255)));
            if ($urandom_range(0, 1) != 0) do_write(a, 1'b0);
            else                           do_read(a);
        end

        // Reset while the target is driving bit7 = 0 of a read.
        tx_src_q.push_back(8'h00);
        gen_start();
        write_byte({SLAVE_ADDR, 1'b1}, 1'b0, ack);
        check("t6_addr_ack", 32'(ack), 32'd0);
        clk_n(2 * Q); bus_if.scl = 1'b1;
        clk_n(Q);
        check("t6_drive_low", 32'(sda), 32'd0);
        reset = 1'b1;
        #1;
        check("t6_sda_released", 32'(sda), 32'd1);
        check("t6_tx_ld", 32'(bus_if.tx_ld), 32'd0);
        check("t6_rx_valid", 32'(bus_if.rx_valid), 32'd0);
        check("t6_rx_data", 32'(bus_if.rx_data), 32'h00);
        check("t6_busy", 32'(bus_if.busy), 32'd0);
        check("t6_rw_dir", 32'(bus_if.rw_dir), 32'd0);
        check("t6_state", 32'(dbg_state), 32'(ST_IDLE));
        check("t6_tx_loaded", 32'(tx_src_q.size()), 32'd0);
        @(negedge clk);
        reset    = 1'b0;
        model_rx = 8'h00;
        clk_n(Q); bus_if.scl = 1'b0;
        gen_stop();
        check("t6_idle_after", 32'(dbg_state), 32'(ST_IDLE));

        // Target recovers for a normal write.
        plan_q = '{8'h4E};
        do_write(SLAVE_ADDR, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
